// File: rtl/load_store_unit.sv
// load_store_unit: sequential byte/half/word load-store front end for a word-only data memory
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_read_data
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;
  localparam logic [2:0] FAULT  = 3'd5;
  logic [2:0]        state, next_state;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, merge_q;
  logic              illegal, misaligned;
  logic [31:0]       shifted, load_val, mask, sdata, merged;
  always_comb begin
    illegal    = is_store ? (funct3[2] || funct3[1:0] == 2'b11)
                          : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misaligned = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    next_state = (state == IDLE) ? (!req ? IDLE :
                                    (illegal || misaligned) ? FAULT :
                                    !is_store ? LOAD :
                                    funct3[1] ? WRITE : RMW_RD) :
                 (state == LOAD || state == WRITE) ? RESP :
                 (state == RMW_RD) ? WRITE : IDLE;
  end
  // Halfword requests are always half-aligned here, so one lane shift serves both sizes
  always_comb begin
    shifted  = mem_read_data >> {addr_q[1:0], 3'b000};
    load_val = funct3_q[1] ? mem_read_data :
               funct3_q[0] ? {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]} :
                             {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
    mask     = funct3_q[1] ? 32'hFFFF_FFFF :
               funct3_q[0] ? 32'h0000_FFFF << {addr_q[1], 4'b0000} :
                             32'h0000_00FF << {addr_q[1:0], 3'b000};
    sdata    = funct3_q[1] ? wdata_q :
               funct3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    merged   = (merge_q & ~mask) | (sdata & mask);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata    <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && req) begin
        funct3_q <= funct3;
        addr_q   <= addr;
        wdata_q  <= wdata;
      end
      if (state == LOAD) rdata <= load_val;
      if (state == RMW_RD) merge_q <= mem_read_data;
    end
  end
  assign busy           = state != IDLE;
  assign done           = state == RESP || state == FAULT;
  assign fault          = state == FAULT;
  assign mem_read       = state == LOAD || state == RMW_RD;
  assign mem_write      = state == WRITE;
  assign mem_write_data = mem_write ? merged : 32'h0;
  assign mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a word memory model for load_store_unit
module tb_load_store_unit;
  logic        clk = 0, rst = 1, req = 0, is_store = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic        busy, done, fault, mem_read, mem_write;
  logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;
  logic [31:0] mem [0:31];
  logic        pre_en = 0;
  logic [4:0]  pre_idx = 0;
  logic [31:0] pre_val = 0;
  int passed = 0, total = 0;
  int lat, nrd, nwr, ovl, rd_cyc, wr_cyc, flt;
  logic [31:0] wa, wd;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .fault(fault),
    .rdata(rdata), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_address[6:2]];
  always @(posedge clk)
    if (mem_write) mem[mem_address[6:2]] <= mem_write_data;
    else if (pre_en) mem[pre_idx] <= pre_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1; pre_idx = idx; pre_val = val;
    @(posedge clk); #1;
    pre_en = 0;
  endtask

  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bit got = 0;
    @(negedge clk);
    req = 1; is_store = st; funct3 = f3; addr = a; wdata = d;
    lat = 0; nrd = 0; nwr = 0; ovl = 0; rd_cyc = 0; wr_cyc = 0; flt = 0; wa = 0; wd = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(posedge clk); #1;
      req = 0;
      if (mem_read) begin nrd++; if (rd_cyc == 0) rd_cyc = i; end
      if (mem_write) begin nwr++; wa = mem_address; wd = mem_write_data; if (wr_cyc == 0) wr_cyc = i; end
      if (mem_read && mem_write) ovl++;
      if (done) begin got = 1; lat = i; flt = int'(fault); end
    end
    if (!got) check("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int dones, writes;
    #12;
    check("rst_ctl", {27'd0, busy, done, fault, mem_read, mem_write}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", mem_address, 0);
    check("rst_wdata", mem_write_data, 0);
    @(negedge clk); rst = 0;
    preload(5'd20, 32'h0);
    // async reset while WRITE is pending: write must be abandoned
    @(negedge clk);
    req = 1; is_store = 1; funct3 = 3'b010; addr = 32'h50; wdata = 32'h55;
    @(posedge clk); #1; req = 0;
    check("pre_rst_mem_write", mem_write, 1);
    #2 rst = 1; #1;
    check("rst_mem_write_drop", mem_write, 0);
    check("rst_busy", busy, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    check("post_rst_ctl", {27'd0, busy, done, fault, mem_read, mem_write}, 0);
    check("post_rst_addr", mem_address, 0);
    check("post_rst_rdata", rdata, 0);
    check("abandoned_write", mem[20], 0);
    // word store then load
    run(1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw_lat", lat, 2);
    check("sw_writes", nwr, 1);
    check("sw_reads", nrd, 0);
    check("sw_addr", wa, 32'h10);
    check("sw_data", wd, 32'hDEADBEEF);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    run(0, 3'b010, 32'h10, 0);
    check("lw_lat", lat, 2);
    check("lw_fault", flt, 0);
    check("lw_rdata", rdata, 32'hDEADBEEF);
    // sub-word loads
    preload(5'd8, 32'h80FF7F01);
    run(0, 3'b000, 32'h20, 0); check("lb_20", rdata, 32'h00000001);
    run(0, 3'b000, 32'h23, 0); check("lb_23", rdata, 32'hFFFFFF80);
    run(0, 3'b100, 32'h22, 0); check("lbu_22", rdata, 32'h000000FF);
    run(0, 3'b001, 32'h22, 0); check("lh_22", rdata, 32'hFFFF80FF);
    run(0, 3'b101, 32'h20, 0); check("lhu_20", rdata, 32'h00007F01);
    check("lhu_lat", lat, 2);
    // read-modify-write stores
    preload(5'd12, 32'h11223344);
    run(1, 3'b000, 32'h31, 32'h000000AB);
    check("sb_lat", lat, 3);
    check("sb_mem", mem[12], 32'h1122AB44);
    check("sb_rw_counts", {nrd[15:0], nwr[15:0]}, {16'd1, 16'd1});
    check("sb_overlap", ovl, 0);
    check("sb_order", rd_cyc < wr_cyc, 1);
    run(1, 3'b001, 32'h32, 32'h0000CDEF);
    check("sh_lat", lat, 3);
    check("sh_mem", mem[12], 32'hCDEFAB44);
    check("sh_overlap", ovl, 0);
    check("sh_order", rd_cyc < wr_cyc, 1);
    // faults
    run(0, 3'b010, 32'h41, 0);
    check("f_lw_lat", lat, 1); check("f_lw_fault", flt, 1);
    check("f_lw_mem", nrd + nwr, 0); check("f_lw_rdata", rdata, 32'h00007F01);
    run(1, 3'b001, 32'h43, 32'h1234);
    check("f_sh_lat", lat, 1); check("f_sh_fault", flt, 1);
    check("f_sh_mem", nrd + nwr, 0); check("f_sh_rdata", rdata, 32'h00007F01);
    run(0, 3'b111, 32'h40, 0);
    check("f_f3_lat", lat, 1); check("f_f3_fault", flt, 1);
    check("f_f3_mem", nrd + nwr, 0); check("f_f3_rdata", rdata, 32'h00007F01);
    // request during LOAD is dropped
    @(negedge clk);
    req = 1; is_store = 0; funct3 = 3'b010; addr = 32'h10;
    @(posedge clk); #1;
    check("busy_in_load", busy, 1);
    is_store = 1; addr = 32'h10; wdata = 32'h12345678;
    dones = 0; writes = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req = 0;
      dones += int'(done);
      writes += int'(mem_write);
    end
    check("ignore_dones", dones, 1);
    check("ignore_writes", writes, 0);
    check("ignore_mem", mem[4], 32'hDEADBEEF);
    check("ignore_rdata", rdata, 32'hDEADBEEF);
    check("ignore_idle", busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
